data_cache_controller: RTL and testbench

Two-way set-associative, write-through, no-write-allocate data cache inserted between the MEM stage's memory request port and the SRAM controller. It accepts the MEM stage's word read/write requests and answers read hits in the same cycle. Misses and all writes are forwarded to the SRAM controller, and `ready` is held low until they finish, so the pipeline freeze mechanism still works.

---
 rtl/data_cache_controller.sv | 187 ++++++++++++++++++
 tb/tb_data_cache_controller.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_cache_controller.sv
// data_cache_controller
//   Two-way set-associative, write-through, no-write-allocate data cache sitting
//   between the MEM stage request port and the SRAM controller. Read hits are
//   answered in the request cycle; read misses fetch a 64-bit line and fill a
//   victim way; every write is forwarded to SRAM and updates the cache only on
//   a hit. `ready` stays low while SRAM is busy so the pipeline freezes.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   rd_en, wr_en             MEM-stage requests, held until ready=1 (wr_en wins)
//   address                  byte address: [2] word, [8:3] index, [18:9] tag
//   write_data               store data
//   read_data                load data, valid when ready=1 and rd_en=1
//   ready                    request complete
//   sram_rd_en, sram_wr_en   line read / word write request to SRAM controller
//   sram_address             line-aligned for reads, unchanged for writes
//   sram_wdata               store data to SRAM
//   sram_rdata               returned line, [31:0] word 0, [63:32] word 1
//   sram_ready               one-cycle completion pulse from SRAM controller

module data_cache_controller #(
    parameter int SETS  = 64,
    parameter int TAG_W = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic        sram_rd_en,
    output logic        sram_wr_en,
    output logic [31:0] sram_address,
    output logic [31:0] sram_wdata,
    input  logic [63:0] sram_rdata,
    input  logic        sram_ready
);

    localparam int IDX_W = $clog2(SETS);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_MISS = 2'd1,
        S_WRITE   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    // Control state (reset)
    logic [SETS-1:0]  r_valid0;
    logic [SETS-1:0]  r_valid1;
    logic [SETS-1:0]  r_lru;      // 0: way 0 is next victim

    // Storage (not reset; guarded by valid bits)
    logic [TAG_W-1:0] r_tag0  [SETS];
    logic [TAG_W-1:0] r_tag1  [SETS];
    logic [63:0]      r_line0 [SETS];
    logic [63:0]      r_line1 [SETS];

    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic             w_word;
    logic             w_hit0;
    logic             w_hit1;
    logic             w_hit;
    logic [63:0]      w_hit_line;
    logic [31:0]      w_hit_word;
    logic [31:0]      w_fill_word;
    logic             w_victim;
    logic             w_rd_hit;
    logic             w_fill;
    logic             w_wr_upd;

    assign w_idx  = address[3 +: IDX_W];
    assign w_tag  = address[3 + IDX_W +: TAG_W];
    assign w_word = address[2];

    assign w_hit0 = r_valid0[w_idx] && (r_tag0[w_idx] == w_tag);
    assign w_hit1 = r_valid1[w_idx] && (r_tag1[w_idx] == w_tag);
    assign w_hit  = w_hit0 || w_hit1;

    assign w_hit_line  = w_hit1 ? r_line1[w_idx] : r_line0[w_idx];
    assign w_hit_word  = w_word ? w_hit_line[63:32] : w_hit_line[31:0];
    assign w_fill_word = w_word ? sram_rdata[63:32] : sram_rdata[31:0];

    // An empty way is always preferred over evicting a live line.
    assign w_victim = !r_valid0[w_idx] ? 1'b0 :
                      !r_valid1[w_idx] ? 1'b1 : r_lru[w_idx];

    assign w_rd_hit = (r_state == S_IDLE) && rd_en && !wr_en && w_hit;
    assign w_fill   = (r_state == S_RD_MISS) && sram_ready;
    assign w_wr_upd = (r_state == S_WRITE) && sram_ready && w_hit;

    assign sram_address = (r_state == S_RD_MISS) ? {address[31:3], 3'b000} : address;
    assign sram_wdata   = write_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_valid0 <= '0;
            r_valid1 <= '0;
            r_lru    <= '0;
        end else begin
            r_state <= w_next;
            // After any access the other way becomes the next victim.
            if (w_rd_hit || w_wr_upd) begin
                r_lru[w_idx] <= w_hit0;
            end
            if (w_fill) begin
                if (w_victim) begin
                    r_valid1[w_idx] <= 1'b1;
                end else begin
                    r_valid0[w_idx] <= 1'b1;
                end
                r_lru[w_idx] <= ~w_victim;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_fill) begin
            if (w_victim) begin
                r_tag1[w_idx]  <= w_tag;
                r_line1[w_idx] <= sram_rdata;
            end else begin
                r_tag0[w_idx]  <= w_tag;
                r_line0[w_idx] <= sram_rdata;
            end
        end
        if (w_wr_upd) begin
            if (w_hit1) begin
                if (w_word) r_line1[w_idx][63:32] <= write_data;
                else        r_line1[w_idx][31:0]  <= write_data;
            end else begin
                if (w_word) r_line0[w_idx][63:32] <= write_data;
                else        r_line0[w_idx][31:0]  <= write_data;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        ready      = 1'b0;
        read_data  = '0;
        sram_rd_en = 1'b0;
        sram_wr_en = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (wr_en) begin
                    w_next = S_WRITE;
                end else if (rd_en) begin
                    if (w_hit) begin
                        ready     = 1'b1;
                        read_data = w_hit_word;
                    end else begin
                        w_next = S_RD_MISS;
                    end
                end else begin
                    ready = 1'b1;
                end
            end
            S_RD_MISS: begin
                sram_rd_en = 1'b1;
                if (sram_ready) begin
                    // Returned line is bypassed straight to the load port.
                    ready     = 1'b1;
                    read_data = w_fill_word;
                    w_next    = S_IDLE;
                end
            end
            S_WRITE: begin
                sram_wr_en = 1'b1;
                if (sram_ready) begin
                    ready  = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_data_cache_controller.sv
module tb_data_cache_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic        ready;
    logic        sram_rd_en;
    logic        sram_wr_en;
    logic [31:0] sram_address;
    logic [31:0] sram_wdata;
    logic [63:0] sram_rdata = '0;
    logic        sram_ready = 1'b0;

    always #5 clk = ~clk;

    data_cache_controller #(.SETS(64), .TAG_W(10)) dut (
        .clk          (clk),
        .rst          (rst),
        .rd_en        (rd_en),
        .wr_en        (wr_en),
        .address      (address),
        .write_data   (write_data),
        .read_data    (read_data),
        .ready        (ready),
        .sram_rd_en   (sram_rd_en),
        .sram_wr_en   (sram_wr_en),
        .sram_address (sram_address),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata),
        .sram_ready   (sram_ready)
    );

    int n_vec = 0;
    int n_err = 0;

    // Backing memory, word addressed by address[18:2] (higher bits alias).
    logic [31:0] mem [logic [16:0]];
    // Per set: resident tags, most recently used first, at most two.
    logic [9:0]  rec [64][$];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        logic [16:0] k = a[18:2];
        logic [31:0] k32 = {15'd0, k};
        if (mem.exists(k)) return mem[k];
        return (k32 * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        int s = int'(a[8:3]);
        for (int i = 0; i < rec[s].size(); i++)
            if (rec[s][i] == a[18:9]) return 1'b1;
        return 1'b0;
    endfunction

    // Access a line: make it most recent, dropping the least recent if full.
    function automatic void m_use(input logic [31:0] a);
        int s = int'(a[8:3]);
        for (int i = 0; i < rec[s].size(); i++) begin
            if (rec[s][i] == a[18:9]) begin
                rec[s].delete(i);
                break;
            end
        end
        rec[s].push_front(a[18:9]);
        if (rec[s].size() > 2) void'(rec[s].pop_back());
    endfunction

    function automatic void m_reset();
        for (int s = 0; s < 64; s++) rec[s].delete();
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_read(input logic [31:0] a, input int lat);
        bit          h = m_hit(a);
        logic [31:0] w = mem_rd(a);
        rd_en   = 1'b1;
        wr_en   = 1'b0;
        address = a;
        @(negedge clk);
        chk("rd_ready_first", 64'(ready), 64'(h));
        if (h) begin
            chk("rd_hit_data", 64'(read_data), 64'(w));
        end else begin
            chk("rd_first_sram_rd_en", 64'(sram_rd_en), 64'd0);
            @(posedge clk); #1;
            for (int i = 0; i < lat; i++) begin
                @(negedge clk);
                chk("rdmiss_sram_rd_en", 64'(sram_rd_en), 64'd1);
                chk("rdmiss_sram_wr_en", 64'(sram_wr_en), 64'd0);
                chk("rdmiss_sram_addr", 64'(sram_address), 64'({a[31:3], 3'b000}));
                chk("rdmiss_ready", 64'(ready), 64'd0);
                @(posedge clk); #1;
            end
            sram_ready = 1'b1;
            sram_rdata = {mem_rd({a[31:3], 3'b100}), mem_rd({a[31:3], 3'b000})};
            @(negedge clk);
            chk("rdmiss_done_ready", 64'(ready), 64'd1);
            chk("rdmiss_bypass_data", 64'(read_data), 64'(w));
        end
        @(posedge clk); #1;
        rd_en      = 1'b0;
        sram_ready = 1'b0;
        m_use(a);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int lat);
        bit h = m_hit(a);
        wr_en      = 1'b1;
        rd_en      = 1'b0;
        address    = a;
        write_data = d;
        @(negedge clk);
        chk("wr_ready_first", 64'(ready), 64'd0);
        chk("wr_first_sram_wr_en", 64'(sram_wr_en), 64'd0);
        @(posedge clk); #1;
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            chk("wr_sram_wr_en", 64'(sram_wr_en), 64'd1);
            chk("wr_sram_rd_en", 64'(sram_rd_en), 64'd0);
            chk("wr_sram_addr", 64'(sram_address), 64'(a));
            chk("wr_sram_wdata", 64'(sram_wdata), 64'(d));
            chk("wr_ready", 64'(ready), 64'd0);
            @(posedge clk); #1;
        end
        sram_ready = 1'b1;
        @(negedge clk);
        chk("wr_done_ready", 64'(ready), 64'd1);
        chk("wr_done_sram_wr_en", 64'(sram_wr_en), 64'd1);
        @(posedge clk); #1;
        wr_en      = 1'b0;
        sram_ready = 1'b0;
        mem[a[18:2]] = d;
        if (h) m_use(a);
    endtask

    task automatic chk_idle(input string tag);
        @(negedge clk);
        chk({tag, "_ready"}, 64'(ready), 64'd1);
        chk({tag, "_sram_rd_en"}, 64'(sram_rd_en), 64'd0);
        chk({tag, "_sram_wr_en"}, 64'(sram_wr_en), 64'd0);
        chk({tag, "_read_data"}, 64'(read_data), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] a;
        m_reset();

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_sram_rd_en", 64'(sram_rd_en), 64'd0);
        chk("rst_sram_wr_en", 64'(sram_wr_en), 64'd0);
        chk("rst_read_data", 64'(read_data), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk_idle("idle");

        // Cold read miss then hit
        mem[17'(32'h404 >> 2)] = 32'h2222_2222;
        mem[17'(32'h400 >> 2)] = 32'h1111_1111;
        do_read(32'h0000_0404, 4);
        do_read(32'h0000_0400, 3);

        // Two-way fill and LRU eviction
        do_read(32'h0000_0000, 2);
        do_read(32'h0000_0200, 2);
        do_read(32'h0000_0400, 2);
        do_read(32'h0000_0200, 2);
        do_read(32'h0000_0000, 2);

        // Write hit, then back-to-back read hit followed by write
        do_read(32'h0000_0008, 1);
        do_write(32'h0000_000C, 32'hDEAD_BEEF, 3);
        do_read(32'h0000_000C, 1);
        do_read(32'h0000_0008, 1);
        do_write(32'h0000_0008, 32'h0BAD_F00D, 2);
        do_read(32'h0000_0008, 1);

        // sram_ready pulse while idle is ignored
        sram_ready = 1'b1;
        @(negedge clk);
        chk("idle_pulse_ready", 64'(ready), 64'd1);
        chk("idle_pulse_sram_rd_en", 64'(sram_rd_en), 64'd0);
        @(posedge clk); #1;
        sram_ready = 1'b0;
        chk_idle("after_pulse");

        // Write miss does not allocate
        do_write(32'h0000_1000, 32'hCAFE_0001, 2);
        do_read(32'h0000_1000, 2);

        // Reset two cycles into a read miss
        a = 32'h0000_2010;
        rd_en = 1'b1;
        address = a;
        @(negedge clk);
        chk("rm_ready_first", 64'(ready), 64'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rm_sram_rd_en", 64'(sram_rd_en), 64'd1);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        rd_en = 1'b0;
        #1;
        chk("rm_rst_sram_rd_en", 64'(sram_rd_en), 64'd0);
        chk("rm_rst_ready", 64'(ready), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        m_reset();
        do_read(a, 2);
        do_read(32'h0000_0404, 1);

        // Randomized traffic over a few sets and tags
        for (int n = 0; n < 300; n++) begin
            a = {13'($urandom), 10'($urandom_range(0, 3)), 6'($urandom_range(0, 3)),
                 1'($urandom), 2'($urandom)};
            if ($urandom_range(0, 9) < 3)
                do_write(a, $urandom, $urandom_range(1, 5));
            else
                do_read(a, $urandom_range(1, 5));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
